// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_pkg
// Description : Shared constants and types for the switch core ingress path.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         MAX_PREAMBLE  = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_strip_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    // Count one event per cycle while below the all-ones ceiling.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
        end else if (inc_i && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/rx_preamble_stripper.sv
`default_nettype none
// ============================================================================
// Module      : rx_preamble_stripper
// Description : GMII RX lane framer. Removes preamble/SFD, forwards DA..FCS
//               with a clean frame strobe, flags runt/oversize/bad preamble
//               and keeps saturating good/bad frame statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_preamble_stripper
    import switch_pkg::*;
#(
    parameter int P_MAX_LEN   = 1518,
    parameter int P_MIN_LEN   = 64,
    parameter int P_CNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   link_sync_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_ctrl_i,
    output logic [7:0]             data_o,
    output logic                   ctrl_o,
    output logic                   frame_done_o,
    output logic                   runt_o,
    output logic                   oversize_o,
    output logic                   bad_preamble_o,
    output logic [P_CNT_WIDTH-1:0] frames_ok_o,
    output logic [P_CNT_WIDTH-1:0] frames_bad_o
);

    localparam int                   C_LEN_W   = $clog2(P_MAX_LEN + 1);
    localparam int                   C_PRE_W   = $clog2(MAX_PREAMBLE + 1);
    localparam logic [C_LEN_W-1:0]   C_MAX_LEN = C_LEN_W'(P_MAX_LEN);
    localparam logic [C_LEN_W-1:0]   C_MIN_LEN = C_LEN_W'(P_MIN_LEN);
    localparam logic [C_PRE_W-1:0]   C_MAX_PRE = C_PRE_W'(MAX_PREAMBLE);

    rx_strip_state_t      r_state;
    logic [C_LEN_W-1:0]   r_len;
    logic [C_PRE_W-1:0]   r_pre_cnt;
    logic [7:0]           r_data;
    logic                 r_ctrl;
    logic                 r_frame_done;
    logic                 r_runt;
    logic                 r_oversize;
    logic                 r_bad_pre;
    logic                 r_link_abort;

    logic                 w_ok_inc;
    logic                 w_bad_inc;

    // Framing FSM: all outputs are registered; pulses default low each cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_pre_cnt    <= '0;
            r_data       <= '0;
            r_ctrl       <= 1'b0;
            r_frame_done <= 1'b0;
            r_runt       <= 1'b0;
            r_oversize   <= 1'b0;
            r_bad_pre    <= 1'b0;
            r_link_abort <= 1'b0;
        end else begin
            r_data       <= '0;
            r_ctrl       <= 1'b0;
            r_frame_done <= 1'b0;
            r_runt       <= 1'b0;
            r_oversize   <= 1'b0;
            r_bad_pre    <= 1'b0;
            r_link_abort <= 1'b0;

            if (!link_sync_i) begin
                // Loss of peer link: only an in-flight frame is reported.
                if (r_state == ST_DATA) begin
                    r_frame_done <= 1'b1;
                    r_link_abort <= 1'b1;
                end
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_ctrl_i) begin
                            if (rx_data_i == PREAMBLE_BYTE) begin
                                r_state   <= ST_PREAMBLE;
                                r_pre_cnt <= C_PRE_W'(1);
                            end else if (rx_data_i == SFD_BYTE) begin
                                // Shortened preamble: SFD alone opens the frame.
                                r_state <= ST_DATA;
                                r_len   <= '0;
                            end else begin
                                r_state   <= ST_DROP;
                                r_bad_pre <= 1'b1;
                            end
                        end
                    end

                    ST_PREAMBLE: begin
                        if (!rx_ctrl_i) begin
                            r_state   <= ST_IDLE;
                            r_bad_pre <= 1'b1;
                        end else if (rx_data_i == PREAMBLE_BYTE) begin
                            if (r_pre_cnt == C_MAX_PRE) begin
                                r_state   <= ST_DROP;
                                r_bad_pre <= 1'b1;
                            end else begin
                                r_pre_cnt <= r_pre_cnt + C_PRE_W'(1);
                            end
                        end else if (rx_data_i == SFD_BYTE) begin
                            r_state <= ST_DATA;
                            r_len   <= '0;
                        end else begin
                            r_state   <= ST_DROP;
                            r_bad_pre <= 1'b1;
                        end
                    end

                    ST_DATA: begin
                        if (!rx_ctrl_i) begin
                            r_state      <= ST_IDLE;
                            r_frame_done <= 1'b1;
                            r_runt       <= (r_len < C_MIN_LEN);
                        end else if (r_len == C_MAX_LEN) begin
                            // Truncate: the partial frame will fail its FCS downstream.
                            r_state      <= ST_DROP;
                            r_frame_done <= 1'b1;
                            r_oversize   <= 1'b1;
                        end else begin
                            r_ctrl <= 1'b1;
                            r_data <= rx_data_i;
                            r_len  <= r_len + C_LEN_W'(1);
                        end
                    end

                    ST_DROP: begin
                        if (!rx_ctrl_i) begin
                            r_state <= ST_IDLE;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A frame is good only when its end strobe carries no error flag.
    assign w_ok_inc  = r_frame_done & ~r_runt & ~r_oversize & ~r_link_abort;
    assign w_bad_inc = r_runt | r_oversize | r_bad_pre | r_link_abort;

    sat_counter #(
        .WIDTH (P_CNT_WIDTH)
    ) u_ok_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (w_ok_inc),
        .count_o (frames_ok_o)
    );

    sat_counter #(
        .WIDTH (P_CNT_WIDTH)
    ) u_bad_cnt (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .inc_i   (w_bad_inc),
        .count_o (frames_bad_o)
    );

    assign data_o         = r_data;
    assign ctrl_o         = r_ctrl;
    assign frame_done_o   = r_frame_done;
    assign runt_o         = r_runt;
    assign oversize_o     = r_oversize;
    assign bad_preamble_o = r_bad_pre;

endmodule
`default_nettype wire
